// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state encoding used by dmem_responder
//   - word/address geometry constants
//   - addr_bad(): misalignment / out-of-range check for a byte address
package dmem_responder_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int WORD_OFS   = $clog2(WORD_BYTES);  // byte-offset bits below the word index

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // An address is bad if it is not word aligned or if any bit above the
    // word index (depth_log2 words) is set.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input int depth_log2);
        logic bad;
        bad = (a[WORD_OFS-1:0] != '0);
        for (int i = WORD_OFS; i < ADDR_W; i++) begin
            if ((i >= depth_log2 + WORD_OFS) && a[i]) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory responder bus.
//   req/we/addr/wd : request, held by the master until ack
//   rd             : registered read data
//   ack/err        : one-cycle completion pulse, err qualifies ack
//   stall          : freeze request to upstream pipeline registers
// master = MEM stage, slave = dmem_responder.
interface dmem_responder_if
    import dmem_responder_pkg::*;
();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              ack;
    logic              err;
    logic              stall;

    modport master (output req, we, addr, wd, input  rd, ack, err, stall);
    modport slave  (input  req, we, addr, wd, output rd, ack, err, stall);
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port word RAM, no reset.
//   clk    : clock, write on rising edge
//   we     : write enable
//   index  : word index
//   wd     : write data
//   rd_raw : contents at index (combinational). A register sampling rd_raw
//            on the same edge as a write sees the pre-write word (read-first).
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd_raw
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) mem[index] <= wd;
    end

    assign rd_raw = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dmem_responder_if.slave (req/we/addr/wd in; rd/ack/err/stall out)
// A request sampled in IDLE is captured, delayed by WAIT_CYCLES wait states,
// executed on the edge entering RESP, and acknowledged for one cycle in RESP.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enter_resp;

    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wd;

    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic [DATA_W-1:0] cur_wd;
    logic              cur_bad;
    logic              do_access;

    logic [DATA_W-1:0] rd_q;
    logic              err_q;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0]     rd_raw;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    cnt_d = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture: only sampled in IDLE, so changes during WAIT/RESP
    // are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr <= '0;
            cap_we   <= 1'b0;
            cap_wd   <= '0;
        end else if (state_q == ST_IDLE && bus.req) begin
            cap_addr <= bus.addr;
            cap_we   <= bus.we;
            cap_wd   <= bus.wd;
        end
    end

    // With zero wait states the access executes on the capture edge itself,
    // before the capture registers hold the request, so IDLE uses the live bus.
    assign cur_addr = (state_q == ST_IDLE) ? bus.addr : cap_addr;
    assign cur_we   = (state_q == ST_IDLE) ? bus.we   : cap_we;
    assign cur_wd   = (state_q == ST_IDLE) ? bus.wd   : cap_wd;
    assign cur_bad  = addr_bad(cur_addr, DEPTH_LOG2);

    // rst gating keeps a held request from committing while reset is asserted.
    assign do_access = enter_resp & ~rst;
    assign ram_we    = do_access & cur_we & ~cur_bad;
    assign ram_idx   = cur_addr[WORD_OFS +: DEPTH_LOG2];

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk    (clk),
        .we     (ram_we),
        .index  (ram_idx),
        .wd     (cur_wd),
        .rd_raw (rd_raw)
    );

    // rd only moves on a successful read; err_q is set only on the RESP-entry
    // edge, so it is high exactly during the ack cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp & cur_bad;
            if (enter_resp && !cur_we && !cur_bad) rd_q <= rd_raw;
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ack   = (state_q == ST_RESP);
    assign bus.err   = err_q;
    assign bus.stall = ((state_q == ST_IDLE) && bus.req) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with zero wait states, sharing clock and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder_if m2 ();
    dmem_responder_if m0 ();

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(m2));
    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(m0));

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the two-wait-state instance, starting in IDLE.
    // Inputs are scrambled during WAIT to confirm the captured request is used.
    task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        m2.req = 1'b1; m2.we = w; m2.addr = a; m2.wd = d;
        #1;
        chk({tag, ".idle.stall"}, 32'(m2.stall), 32'd1);
        chk({tag, ".idle.ack"},   32'(m2.ack),   32'd0);
        tick();
        chk({tag, ".w1.stall"}, 32'(m2.stall), 32'd1);
        chk({tag, ".w1.ack"},   32'(m2.ack),   32'd0);
        m2.we = ~w; m2.addr = 32'h0; m2.wd = 32'h0;
        tick();
        chk({tag, ".w2.stall"}, 32'(m2.stall), 32'd1);
        chk({tag, ".w2.ack"},   32'(m2.ack),   32'd0);
        tick();
        chk({tag, ".resp.ack"},   32'(m2.ack),   32'd1);
        chk({tag, ".resp.err"},   32'(m2.err),   32'(exp_err));
        chk({tag, ".resp.stall"}, 32'(m2.stall), 32'd0);
        chk({tag, ".resp.rd"},    m2.rd,         exp_rd);
        m2.req = 1'b0;
        tick();
        chk({tag, ".post.ack"},   32'(m2.ack),   32'd0);
        chk({tag, ".post.err"},   32'(m2.err),   32'd0);
        chk({tag, ".post.stall"}, 32'(m2.stall), 32'd0);
        chk({tag, ".post.rd"},    m2.rd,         exp_rd);
    endtask

    // Single transaction on the zero-wait-state instance, starting in IDLE.
    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        m0.req = 1'b1; m0.we = w; m0.addr = a; m0.wd = d;
        #1;
        chk({tag, ".idle.stall"}, 32'(m0.stall), 32'd1);
        chk({tag, ".idle.ack"},   32'(m0.ack),   32'd0);
        tick();
        chk({tag, ".resp.ack"},   32'(m0.ack),   32'd1);
        chk({tag, ".resp.err"},   32'(m0.err),   32'(exp_err));
        chk({tag, ".resp.stall"}, 32'(m0.stall), 32'd0);
        chk({tag, ".resp.rd"},    m0.rd,         exp_rd);
        m0.req = 1'b0;
        tick();
        chk({tag, ".post.ack"}, 32'(m0.ack), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m2.req = 1'b0; m2.we = 1'b0; m2.addr = '0; m2.wd = '0;
        m0.req = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.wd = '0;
        tick();
        chk("rst.ack",   32'(m2.ack),   32'd0);
        chk("rst.err",   32'(m2.err),   32'd0);
        chk("rst.rd",    m2.rd,         32'd0);
        chk("rst.stall", 32'(m2.stall), 32'd0);
        chk("rst0.rd",   m0.rd,         32'd0);
        chk("rst0.ack",  32'(m0.ack),   32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Preload, read latency, write-then-read
        acc2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "wr10");
        acc2(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd10");
        acc2(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, "wr20");
        acc2(1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678, "rd20");

        // Misaligned write must not touch the word at 0x20
        acc2(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, "wr22mis");
        acc2(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd10b");
        acc2(1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678, "rd20b");

        // Out of range: read, and a write whose low bits alias word 4
        acc2(1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h1234_5678, "rd1000oor");
        acc2(1'b1, 32'h0000_1010, 32'h0000_0000, 1'b1, 32'h1234_5678, "wr1010oor");
        acc2(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd10c");

        // Highest in-range word
        acc2(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, "wrffc");
        acc2(1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D, "rdffc");

        // Reset one cycle after acceptance discards the pending write
        acc2(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'hCAFE_F00D, "wr40");
        m2.req = 1'b1; m2.we = 1'b1; m2.addr = 32'h0000_0040; m2.wd = 32'hA5A5_A5A5;
        tick();
        chk("mrst.accept.stall", 32'(m2.stall), 32'd1);
        m2.req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst.ack",   32'(m2.ack),   32'd0);
        chk("mrst.stall", 32'(m2.stall), 32'd0);
        chk("mrst.err",   32'(m2.err),   32'd0);
        chk("mrst.rd",    m2.rd,         32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mrst.after.ack", 32'(m2.ack), 32'd0);
        acc2(1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0BAD_F00D, "rd40");

        // Zero wait states
        acc0(1'b1, 32'h0000_0008, 32'h1111_1111, 1'b0, 32'h0000_0000, "z.wr08");
        acc0(1'b1, 32'h0000_000C, 32'h2222_2222, 1'b0, 32'h0000_0000, "z.wr0c");

        // Back-to-back reads with req held: ack every second cycle
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'h0000_0008;
        #1;
        chk("z.b2b.i1.stall", 32'(m0.stall), 32'd1);
        chk("z.b2b.i1.ack",   32'(m0.ack),   32'd0);
        tick();
        chk("z.b2b.r1.ack",   32'(m0.ack),   32'd1);
        chk("z.b2b.r1.stall", 32'(m0.stall), 32'd0);
        chk("z.b2b.r1.rd",    m0.rd,         32'h1111_1111);
        m0.addr = 32'h0000_000C;
        tick();
        chk("z.b2b.i2.ack",   32'(m0.ack),   32'd0);
        chk("z.b2b.i2.stall", 32'(m0.stall), 32'd1);
        tick();
        chk("z.b2b.r2.ack",   32'(m0.ack),   32'd1);
        chk("z.b2b.r2.err",   32'(m0.err),   32'd0);
        chk("z.b2b.r2.rd",    m0.rd,         32'h2222_2222);
        m0.req = 1'b0;
        tick();
        chk("z.b2b.end.ack",   32'(m0.ack),   32'd0);
        chk("z.b2b.end.stall", 32'(m0.stall), 32'd0);

        // Zero-wait misaligned read keeps rd
        acc0(1'b0, 32'h0000_0009, 32'h0, 1'b1, 32'h2222_2222, "z.rd09mis");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
